operand_feeder: RTL and testbench
=================================

OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 Parameter ARRAY_NUM, default 3, number of systolic rows fed in parallel.
REQ-002 Parameter RAM_DEPTH, default 2048, buffer entries, power of two; ADDR_W = $clog2(RAM_DEPTH).
REQ-003 Parameter DATA_W, default 8*ARRAY_NUM, buffer word width, one byte per row.
REQ-004 The ports SHALL be, in this order:
- iClk, in, 1, single clock, all logic rising-edge.
- iRstN, in, 1, asynchronous active-low reset.
- iWrEn, in, 1, host write strobe.
- iWrAddr, in, ADDR_W, host write address.
- iWrData, in, DATA_W, host write data.
- oWrErr, out, 1, one-cycle pulse when a write is rejected.
- iAddrValid, in, 1, read request from micro_controller.
- iAddr, in, ADDR_W, read address.
- iClearAcc, in, 1, sideband, delayed with the read.
- iInputPattern, in, 8*ARRAY_NUM+8, sideband, delayed with the read.
- iPassDataLeft, in, ARRAY_NUM-1, sideband, delayed with the read.
- oDataValid, out, 1, oData is valid.
- oData, out, DATA_W, buffer word read at iAddr.
- oClearAcc, oInputPattern, oPassDataLeft, out, same widths as inputs, sidebands aligned to oData.
- oBusy, out, 1, high when state is not IDLE.
- oReadCount, out, 16, reads accepted in the current stream.

Function
REQ-005 Fixed read latency of 2 cycles: request sampled at edge N -> oDataValid, oData and all sidebands valid after edge N+2.
REQ-006 Sidebands SHALL travel through a 2-stage pipeline in lockstep with iAddrValid, every cycle, whether or not the read is valid.
REQ-007 When oDataValid is 0, oData SHALL be 0 and oClearAcc 0; oInputPattern and oPassDataLeft carry their delayed values.
REQ-008 States: IDLE, STREAM, DRAIN.
REQ-009 IDLE -> STREAM on iAddrValid=1.
REQ-010 STREAM -> DRAIN on iAddrValid=0.
REQ-011 DRAIN -> STREAM on iAddrValid=1.
REQ-012 DRAIN -> IDLE when both pipeline valid stages are 0 and iAddrValid=0.
REQ-013 Writes are accepted only in IDLE.
REQ-014 A write with iWrEn=1 in STREAM or DRAIN SHALL be dropped, and oWrErr SHALL pulse high the next cycle.
REQ-015 A write in the same cycle as the IDLE->STREAM request SHALL be accepted, and the read is read-first: it returns the old contents.
REQ-016 oReadCount SHALL clear to 0 on IDLE->STREAM, then count 1 for the first read, incrementing for each iAddrValid=1 cycle.
REQ-017 oReadCount saturates at 16'hFFFF and holds its value in IDLE.
REQ-018 Address width equals ADDR_W; no out-of-range handling is required.

Reset
REQ-019 Asserting iRstN low SHALL asynchronously clear the state to IDLE and clear oDataValid, oData, oClearAcc, oInputPattern, oPassDataLeft, oWrErr, oBusy, oReadCount and all pipeline stages to 0.
REQ-020 Buffer contents are not reset; reads before any write return undefined data, and the bench SHALL NOT check them.
REQ-021 Reset during STREAM SHALL discard in-flight reads, and no oDataValid shall follow the deassertion of reset.

Structure
REQ-022 Package systolic_pkg SHALL hold the ARRAY_NUM and RAM_DEPTH defaults, the ADDR_W function/constant, and the feeder_state_t enum (IDLE, STREAM, DRAIN).
REQ-023 Sub-module feeder_ram: 1 write port and 1 read port, synchronous read, read-first, no reset; operand_feeder adds the output register stage.

Verification
REQ-024 Write 0x0A0B0C to addr 5 in IDLE, then iAddrValid=1, iAddr=5 for one cycle -> exactly 2 cycles later oDataValid=1 and oData=0x0A0B0C for one cycle; oBusy returns 0 after DRAIN.
REQ-025 Stream addrs 0..9 back-to-back with iInputPattern=index -> 10 consecutive valid outputs in order, each with the matching pattern; oReadCount=10.
REQ-026 iWrEn=1 to addr 3 during STREAM -> oWrErr pulses one cycle; a later read of addr 3 returns the pre-stream value.
REQ-027 Same-cycle write of 0x11 and read at addr 7 (old value 0x22) in IDLE -> output 0x22; a re-read returns 0x11.
REQ-028 Assert iRstN low 1 cycle after a read is issued -> all outputs 0; no oDataValid after release; state is IDLE.
REQ-029 Gap pattern valid, invalid, valid -> STREAM, DRAIN, STREAM with no return to IDLE; oReadCount=2.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared defaults, address-width helper and feeder state encoding for the systolic operand path.
package systolic_pkg;

    localparam int ARRAY_NUM_DEF = 3;
    localparam int RAM_DEPTH_DEF = 2048;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/operand_feeder_if.sv
// Buffer access bundle between the feeder control (master) and its RAM (slave).
interface operand_feeder_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 24
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
endinterface

// File: rtl/feeder_ram.sv
// Operand buffer: 1W/1R, synchronous read-first, one cycle read latency.
// No reset and no backpressure; a write and read to the same address return the old word.
module feeder_ram #(
    parameter int RAM_DEPTH = 2048,
    parameter int DATA_W    = 24
) (
    input logic              iClk,
    operand_feeder_if.slave  ram
);
    logic [DATA_W-1:0] mem_q [RAM_DEPTH];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge iClk) begin
        if (ram.wr_en) mem_q[ram.wr_addr] <= ram.wr_data;
        if (ram.rd_en) rd_q <= mem_q[ram.rd_addr];
    end

    assign ram.rd_data = rd_q;
endmodule

// File: rtl/operand_feeder.sv
// Feeds buffered operand words plus aligned sidebands to the systolic rows, two cycles after request.
// No backpressure on reads; host writes outside IDLE are dropped and flagged on oWrErr.
module operand_feeder
    import systolic_pkg::*;
#(
    parameter int  ARRAY_NUM = ARRAY_NUM_DEF,
    parameter int  RAM_DEPTH = RAM_DEPTH_DEF,
    parameter int  DATA_W    = 8*ARRAY_NUM,
    localparam int ADDR_W    = addr_w(RAM_DEPTH),
    localparam int PAT_W     = 8*ARRAY_NUM+8
) (
    input  logic                 iClk,
    input  logic                 iRstN,
    input  logic                 iWrEn,
    input  logic [ADDR_W-1:0]    iWrAddr,
    input  logic [DATA_W-1:0]    iWrData,
    output logic                 oWrErr,
    input  logic                 iAddrValid,
    input  logic [ADDR_W-1:0]    iAddr,
    input  logic                 iClearAcc,
    input  logic [PAT_W-1:0]     iInputPattern,
    input  logic [ARRAY_NUM-2:0] iPassDataLeft,
    output logic                 oDataValid,
    output logic [DATA_W-1:0]    oData,
    output logic                 oClearAcc,
    output logic [PAT_W-1:0]     oInputPattern,
    output logic [ARRAY_NUM-2:0] oPassDataLeft,
    output logic                 oBusy,
    output logic [15:0]          oReadCount
);
    feeder_state_t state_q, state_d;

    logic                 vld1_q, clr1_q;
    logic [PAT_W-1:0]     pat1_q;
    logic [ARRAY_NUM-2:0] pass1_q;

    logic                 vld_q, clr_q, wr_err_q;
    logic [DATA_W-1:0]    data_q;
    logic [PAT_W-1:0]     pat_q;
    logic [ARRAY_NUM-2:0] pass_q;
    logic [15:0]          cnt_q, cnt_d;

    logic wr_accept;
    assign wr_accept = iWrEn && (state_q == IDLE);

    operand_feeder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_if ();

    assign ram_if.wr_en   = wr_accept;
    assign ram_if.wr_addr = iWrAddr;
    assign ram_if.wr_data = iWrData;
    assign ram_if.rd_en   = iAddrValid;
    assign ram_if.rd_addr = iAddr;

    feeder_ram #(.RAM_DEPTH(RAM_DEPTH), .DATA_W(DATA_W)) u_ram (
        .iClk (iClk),
        .ram  (ram_if.slave)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iAddrValid) state_d = STREAM;
            STREAM:  if (!iAddrValid) state_d = DRAIN;
            DRAIN: begin
                if (iAddrValid)             state_d = STREAM;
                else if (!vld1_q && !vld_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The first read of a stream restarts the count at 1; DRAIN->STREAM keeps counting.
    always_comb begin
        cnt_d = cnt_q;
        if (iAddrValid) begin
            if (state_q == IDLE)        cnt_d = 16'd1;
            else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
            vld1_q   <= 1'b0;
            clr1_q   <= 1'b0;
            pat1_q   <= '0;
            pass1_q  <= '0;
            vld_q    <= 1'b0;
            clr_q    <= 1'b0;
            data_q   <= '0;
            pat_q    <= '0;
            pass_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_err_q <= iWrEn && (state_q != IDLE);
            vld1_q   <= iAddrValid;
            clr1_q   <= iClearAcc;
            pat1_q   <= iInputPattern;
            pass1_q  <= iPassDataLeft;
            vld_q    <= vld1_q;
            clr_q    <= vld1_q & clr1_q;
            data_q   <= vld1_q ? ram_if.rd_data : '0;
            pat_q    <= pat1_q;
            pass_q   <= pass1_q;
        end
    end

    assign oWrErr        = wr_err_q;
    assign oDataValid    = vld_q;
    assign oData         = data_q;
    assign oClearAcc     = clr_q;
    assign oInputPattern = pat_q;
    assign oPassDataLeft = pass_q;
    assign oBusy         = (state_q != IDLE);
    assign oReadCount    = cnt_q;
endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder: write/read latency, streaming, write rejection, read-first, reset, gaps.
module tb_operand_feeder;
    import systolic_pkg::*;

    localparam int AN = 3;
    localparam int AW = 11;
    localparam int DW = 24;
    localparam int PW = 8*AN+8;

    logic          iClk = 1'b0;
    logic          iRstN;
    logic          iWrEn;
    logic [AW-1:0] iWrAddr;
    logic [DW-1:0] iWrData;
    logic          oWrErr;
    logic          iAddrValid;
    logic [AW-1:0] iAddr;
    logic          iClearAcc;
    logic [PW-1:0] iInputPattern;
    logic [AN-2:0] iPassDataLeft;
    logic          oDataValid;
    logic [DW-1:0] oData;
    logic          oClearAcc;
    logic [PW-1:0] oInputPattern;
    logic [AN-2:0] oPassDataLeft;
    logic          oBusy;
    logic [15:0]   oReadCount;

    int n_checks = 0;
    int n_err    = 0;

    always #5 iClk = ~iClk;

    operand_feeder #(.ARRAY_NUM(AN), .RAM_DEPTH(2048)) dut (
        .iClk(iClk), .iRstN(iRstN),
        .iWrEn(iWrEn), .iWrAddr(iWrAddr), .iWrData(iWrData), .oWrErr(oWrErr),
        .iAddrValid(iAddrValid), .iAddr(iAddr),
        .iClearAcc(iClearAcc), .iInputPattern(iInputPattern), .iPassDataLeft(iPassDataLeft),
        .oDataValid(oDataValid), .oData(oData),
        .oClearAcc(oClearAcc), .oInputPattern(oInputPattern), .oPassDataLeft(oPassDataLeft),
        .oBusy(oBusy), .oReadCount(oReadCount)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        iWrEn = 1'b1; iWrAddr = a; iWrData = d;
        tick();
        iWrEn = 1'b0;
    endtask

    task automatic read_one(input logic [AW-1:0] a, output logic v, output logic [DW-1:0] d);
        iAddrValid = 1'b1; iAddr = a;
        tick();
        iAddrValid = 1'b0;
        tick();
        v = oDataValid;
        d = oData;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 8; k++) begin
            if (!oBusy) break;
            tick();
        end
        check(tag, 64'(oBusy), 64'd0);
    endtask

    function automatic logic [DW-1:0] word_of(input int i);
        return 24'hA00000 | (24'(i) << 8) | 24'(i);
    endfunction

    initial begin
        logic          v;
        logic [DW-1:0] d;

        iRstN = 1'b0; iWrEn = 1'b0; iWrAddr = '0; iWrData = '0;
        iAddrValid = 1'b0; iAddr = '0; iClearAcc = 1'b0;
        iInputPattern = '0; iPassDataLeft = '0;
        repeat (2) @(posedge iClk);
        #1;
        check("rst_valid", 64'(oDataValid), 64'd0);
        check("rst_data",  64'(oData),      64'd0);
        check("rst_busy",  64'(oBusy),      64'd0);
        check("rst_count", 64'(oReadCount), 64'd0);
        check("rst_wrerr", 64'(oWrErr),     64'd0);
        iRstN = 1'b1;
        tick();

        // Single write then single read with sidebands
        write_word(11'd5, 24'h0A0B0C);
        check("wr_idle_noerr", 64'(oWrErr), 64'd0);
        iAddrValid = 1'b1; iAddr = 11'd5; iClearAcc = 1'b1;
        iInputPattern = 32'h55; iPassDataLeft = 2'b10;
        tick();
        iAddrValid = 1'b0; iClearAcc = 1'b0; iInputPattern = 32'hAA; iPassDataLeft = 2'b00;
        check("lat1_valid", 64'(oDataValid), 64'd0);
        check("lat1_busy",  64'(oBusy),      64'd1);
        check("lat1_count", 64'(oReadCount), 64'd1);
        tick();
        check("lat2_valid", 64'(oDataValid),    64'd1);
        check("lat2_data",  64'(oData),         64'h0A0B0C);
        check("lat2_clr",   64'(oClearAcc),     64'd1);
        check("lat2_pat",   64'(oInputPattern), 64'h55);
        check("lat2_pass",  64'(oPassDataLeft), 64'h2);
        tick();
        check("lat3_valid", 64'(oDataValid),    64'd0);
        check("lat3_data",  64'(oData),         64'd0);
        check("lat3_clr",   64'(oClearAcc),     64'd0);
        check("lat3_pat",   64'(oInputPattern), 64'hAA);
        wait_idle("single_idle");

        // Back-to-back stream of addresses 0..9
        for (int i = 0; i < 10; i++) write_word(AW'(i), word_of(i));
        for (int i = 0; i < 10; i++) begin
            iAddrValid = 1'b1; iAddr = AW'(i); iInputPattern = PW'(i);
            tick();
            if (i == 0) check("strm_first_invalid", 64'(oDataValid), 64'd0);
            else begin
                check($sformatf("strm_valid_%0d", i-1), 64'(oDataValid),    64'd1);
                check($sformatf("strm_data_%0d", i-1),  64'(oData),         64'(word_of(i-1)));
                check($sformatf("strm_pat_%0d", i-1),   64'(oInputPattern), 64'(i-1));
            end
        end
        check("strm_count", 64'(oReadCount), 64'd10);
        iAddrValid = 1'b0; iInputPattern = '0;
        tick();
        check("strm_valid_9", 64'(oDataValid),    64'd1);
        check("strm_data_9",  64'(oData),         64'(word_of(9)));
        check("strm_pat_9",   64'(oInputPattern), 64'd9);
        tick();
        check("strm_end_invalid", 64'(oDataValid), 64'd0);
        wait_idle("strm_idle");
        check("strm_count_hold", 64'(oReadCount), 64'd10);

        // Write during STREAM is rejected
        iAddrValid = 1'b1; iAddr = 11'd0;
        tick();
        iWrEn = 1'b1; iWrAddr = 11'd3; iWrData = 24'hFFFFFF;
        tick();
        iWrEn = 1'b0; iAddrValid = 1'b0;
        check("wrerr_pulse", 64'(oWrErr), 64'd1);
        tick();
        check("wrerr_clear", 64'(oWrErr), 64'd0);
        wait_idle("wrerr_idle");
        read_one(11'd3, v, d);
        check("wrerr_rd_valid", 64'(v), 64'd1);
        check("wrerr_rd_data",  64'(d), 64'(word_of(3)));
        wait_idle("wrerr_rd_idle");

        // Same-cycle write and read in IDLE is read-first
        write_word(11'd7, 24'h000022);
        iWrEn = 1'b1; iWrAddr = 11'd7; iWrData = 24'h000011;
        iAddrValid = 1'b1; iAddr = 11'd7;
        tick();
        iWrEn = 1'b0; iAddrValid = 1'b0;
        check("rf_wrerr", 64'(oWrErr), 64'd0);
        tick();
        check("rf_valid", 64'(oDataValid), 64'd1);
        check("rf_old",   64'(oData),      64'h22);
        wait_idle("rf_idle");
        read_one(11'd7, v, d);
        check("rf_new", 64'(d), 64'h11);
        wait_idle("rf_new_idle");

        // Gap pattern: valid, invalid, valid
        iAddrValid = 1'b1; iAddr = 11'd0;
        tick();
        check("gap_stream1", 64'(dut.state_q), 64'(STREAM));
        iAddrValid = 1'b0;
        tick();
        check("gap_drain", 64'(dut.state_q), 64'(DRAIN));
        iAddrValid = 1'b1; iAddr = 11'd1;
        tick();
        iAddrValid = 1'b0;
        check("gap_stream2", 64'(dut.state_q), 64'(STREAM));
        check("gap_count",   64'(oReadCount),  64'd2);
        wait_idle("gap_idle");
        check("gap_count_hold", 64'(oReadCount), 64'd2);

        // Reset one cycle after a read is issued
        iAddrValid = 1'b1; iAddr = 11'd5; iClearAcc = 1'b1; iInputPattern = 32'h77; iPassDataLeft = 2'b11;
        tick();
        iAddrValid = 1'b0; iClearAcc = 1'b0; iInputPattern = '0; iPassDataLeft = '0;
        #1 iRstN = 1'b0;
        #1;
        check("rstm_valid", 64'(oDataValid),    64'd0);
        check("rstm_data",  64'(oData),         64'd0);
        check("rstm_clr",   64'(oClearAcc),     64'd0);
        check("rstm_pat",   64'(oInputPattern), 64'd0);
        check("rstm_pass",  64'(oPassDataLeft), 64'd0);
        check("rstm_busy",  64'(oBusy),         64'd0);
        check("rstm_count", 64'(oReadCount),    64'd0);
        check("rstm_state", 64'(dut.state_q),   64'(IDLE));
        tick();
        iRstN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rstm_novalid_%0d", k), 64'(oDataValid), 64'd0);
        end
        check("rstm_idle_after", 64'(dut.state_q), 64'(IDLE));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
